// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file constants and the register index type used by the ID/EXE/MEM/WB stage registers.
package rf_pkg;
    localparam int RF_NUM_REGS     = 16;
    localparam int RF_DATA_W       = 32;
    localparam int RF_NUM_RD       = 2;
    localparam int RF_MAX_INFLIGHT = 3;
    localparam int RF_AW           = $clog2(RF_NUM_REGS);
    localparam int RF_CW           = $clog2(RF_MAX_INFLIGHT + 1);

    typedef logic [RF_AW-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter: saturating up/down count with clear, plus an underflow flag.
module sb_counter
    import rf_pkg::*;
#(
    parameter int MAX = RF_MAX_INFLIGHT,
    localparam int CW = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full,
    output logic zero,
    output logic one,
    output logic err
);
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          inc_ok;
    logic          dec_ok;

    assign zero   = (cnt_reg == '0);
    assign one    = (cnt_reg == CW'(1));
    assign full   = (cnt_reg == CW'(MAX));
    assign inc_ok = inc & ~full;
    assign dec_ok = dec & ~zero;
    // A write-back with nothing outstanding is a protocol error, unless a flush is discarding marks anyway.
    assign err    = dec & zero & ~clr;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr)
            cnt_next = '0;
        else if (inc_ok && !dec_ok)
            cnt_next = cnt_reg + 1'b1;
        else if (dec_ok && !inc_ok)
            cnt_next = cnt_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register pending-write scoreboard and hazard detection.
// Define RF_WB_BYPASS_EN to forward same-cycle write-back data to the read ports and release the stall early.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS     = RF_NUM_REGS,
    parameter int DATA_W       = RF_DATA_W,
    parameter int NUM_RD       = RF_NUM_RD,
    parameter int MAX_INFLIGHT = RF_MAX_INFLIGHT,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    input  logic [NUM_RD-1:0]        rd_used,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     hazard,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_dest,
    output logic                     issue_full,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_dest,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     flush,
    output logic                     sb_err
);
    logic [DATA_W-1:0]   regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0] full;
    logic [NUM_REGS-1:0] zero;
    logic [NUM_REGS-1:0] one;
    logic [NUM_REGS-1:0] err;
    logic [NUM_RD-1:0]   busy;
    logic                sb_err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs_reg[r] <= '0;
        end else if (wb_en) begin
            regs_reg[wb_dest] <= wb_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
            sb_counter #(.MAX(MAX_INFLIGHT)) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc  (issue_en && (issue_dest == AW'(gi))),
                .dec  (wb_en && (wb_dest == AW'(gi))),
                .clr  (flush),
                .full (full[gi]),
                .zero (zero[gi]),
                .one  (one[gi]),
                .err  (err[gi])
            );
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] ra;
            logic          byp;
            assign ra = rd_addr[gi*AW +: AW];
`ifdef RF_WB_BYPASS_EN
            assign byp = wb_en && (wb_dest == ra);
`else
            assign byp = 1'b0;
`endif
            assign rd_data[gi*DATA_W +: DATA_W] = byp ? wb_data : regs_reg[ra];
            // The last outstanding write landing this cycle is already visible through the bypass.
            assign busy[gi] = rd_used[gi] & ~zero[ra] & ~(one[ra] & byp);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sb_err_reg <= 1'b0;
        else if (|err)
            sb_err_reg <= 1'b1;
    end

    assign hazard     = |busy;
    assign issue_full = full[issue_dest];
    assign sb_err     = sb_err_reg;
endmodule
